time_set_controller: RTL and testbench
======================================

Name: time_set_controller

Overview:
Sequencer for the clock display selector and the timekeeping counter. Owns the set-mode state machine: captures live time into edit registers, steps hour/minute/second selection, applies increment/decrement with field wrap, and generates the blink pulse. Drives the selector's clockon, hset, mset, sset, pulse and ih/im/is inputs. Issues a one-cycle load strobe so the timekeeper adopts the edited time.

Parameters:
BLINK_CYCLES, 25000000, clk cycles per pulse half-period (pulse toggles every BLINK_CYCLES cycles)
TIMEOUT_S, 30, tick_1hz strobes without a button press before set mode aborts

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
tick_1hz  input  1  one-cycle strobe, once per second
btn_set  input  1  one-cycle strobe, debounced upstream; enter set mode / advance field
btn_inc  input  1  one-cycle strobe; increment selected field
btn_dec  input  1  one-cycle strobe; decrement selected field
h  input  7  live hours, 0..23
m  input  7  live minutes, 0..59
s  input  7  live seconds, 0..59
ih  output  7  edited hours
im  output  7  edited minutes
is  output  7  edited seconds
clockon  output  1  1 = selector shows live time, 0 = shows edit registers
hset  output  1  hour field selected
mset  output  1  minute field selected
sset  output  1  second field selected
pulse  output  1  blink phase for the selected field
load  output  1  one-cycle commit strobe; ih/im/is valid while high

Behaviour:
- All outputs registered. Reset: state RUN, clockon=1, hset=mset=sset=0, ih=im=is=0, pulse=0, load=0, blink and timeout counters cleared. Reset overrides every other input in the same cycle, including mid-edit: edits are discarded and load stays 0.
- States: RUN, SET_H, SET_M, SET_S, COMMIT.
- RUN: clockon=1, selects=0, pulse=0. If btn_set is high in cycle N, h/m/s are sampled in cycle N into ih/im/is. State is SET_H from N+1 with clockon=0 and hset=1.
- SET_H -> SET_M -> SET_S on btn_set. Exactly one of hset/mset/sset is 1, matching the state.
- SET_S + btn_set -> COMMIT. COMMIT lasts one cycle: load=1, clockon=0, selects=0. The next state is RUN with clockon=1.
- btn_inc in a SET state adds 1 to the selected field only. Hours wrap 23->0; minutes and seconds wrap 59->0.
- btn_dec subtracts 1. Hours wrap 0->23; minutes and seconds wrap 0->59.
- Fields captured out of range (h>23, m/s>59) go to 0 on the next inc and to the field max on the next dec.
- Updated field value is visible the cycle after the strobe.
- Simultaneous events:
  - btn_set with btn_inc or btn_dec: btn_set wins, inc/dec ignored.
  - btn_inc with btn_dec: no change, but the press still counts as activity.
  - Buttons are ignored in COMMIT. btn_inc and btn_dec are ignored in RUN.
- Blink: in SET states a counter runs 0..BLINK_CYCLES-1. pulse toggles on wrap. Counter and pulse clear to 0 on every state change and on every inc/dec, so the field shows steadily right after an edit. pulse=0 in RUN and COMMIT.
- Timeout: in SET states a counter increments on tick_1hz and clears on any btn_* strobe. When the count reaches TIMEOUT_S, the next state is RUN with no load; ih/im/is keep their values. The counter is cleared outside SET states.
- ih/im/is hold their values outside SET states and change only on capture or edit.

Test Plan:
- Reset then idle 100 cycles -> clockon=1, all selects 0, pulse=0, load=0, ih=im=is=0.
- h=13, m=45, s=7; btn_set -> next cycle clockon=0, hset=1, ih=13, im=45, is=7.
- In SET_H: ih=23 + btn_inc -> ih=0. In SET_M: im=0 + btn_dec -> im=59. In SET_S: is=59 + btn_inc -> is=0. btn_inc and btn_dec together -> no change.
- Full cycle: set, inc x2 (ih=15), set, set, set -> load high exactly 1 cycle with ih=15, im=45, is=7; clockon=1 the cycle after.
- BLINK_CYCLES=4 in SET_M: pulse toggles every 4 cycles. A btn_inc forces pulse=0 and restarts the count.
- TIMEOUT_S=3: enter SET_H, 3 tick_1hz strobes with no buttons -> RUN, load never asserted. Repeat with a btn_inc before the 3rd tick -> stays in SET_H. Assert rst during SET_S -> reset values next cycle, no load.

Source files
------------

// File: rtl/time_set_controller.sv
// Set-mode sequencer for the clock display: captures live time, edits h/m/s with wrap,
// generates the blink phase and commits the edited time to the timekeeper with a load strobe.
//
// state  | meaning
// RUN    | selector shows live time, buttons other than set ignored
// SET_H  | editing hours
// SET_M  | editing minutes
// SET_S  | editing seconds
// COMMIT | one-cycle load of ih/im/is into the timekeeper
module time_set_controller #(
  parameter int BLINK_CYCLES = 25000000,
  parameter int TIMEOUT_S    = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [6:0] h,
  input  logic [6:0] m,
  input  logic [6:0] s,
  output logic [6:0] ih,
  output logic [6:0] im,
  output logic [6:0] is,
  output logic       clockon,
  output logic       hset,
  output logic       mset,
  output logic       sset,
  output logic       pulse,
  output logic       load
);

  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam logic [BW-1:0] BLINK_RELOAD = BW'(BLINK_CYCLES - 1);
  localparam logic [TW-1:0] TMO_RELOAD   = TW'(TIMEOUT_S);

  typedef enum logic [2:0] {RUN, SET_H, SET_M, SET_S, COMMIT} state_t;

  state_t          state, state_n;
  logic [6:0]      ih_n, im_n, is_n;
  logic [BW-1:0]   blink_cnt, blink_cnt_n;
  logic            pulse_n;
  logic [TW-1:0]   tmo_cnt, tmo_cnt_n;
  logic            in_set, edit_inc, edit_dec, any_btn;

  // Out-of-range captures land on 0 going up and on the field max going down.
  function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] max);
    return (v >= max) ? 7'd0 : v + 7'd1;
  endfunction

  function automatic logic [6:0] wrap_dec(input logic [6:0] v, input logic [6:0] max);
    return (v == 7'd0 || v > max) ? max : v - 7'd1;
  endfunction

  always_comb begin
    state_n     = state;
    ih_n        = ih;
    im_n        = im;
    is_n        = is;
    blink_cnt_n = blink_cnt;
    pulse_n     = pulse;
    tmo_cnt_n   = tmo_cnt;
    in_set      = (state == SET_H) || (state == SET_M) || (state == SET_S);
    any_btn     = btn_set || btn_inc || btn_dec;
    edit_inc    = in_set && !btn_set && btn_inc && !btn_dec;
    edit_dec    = in_set && !btn_set && btn_dec && !btn_inc;

    case (state)
      RUN: begin
        if (btn_set) begin
          ih_n    = h;
          im_n    = m;
          is_n    = s;
          state_n = SET_H;
        end
      end
      SET_H: begin
        if (btn_set)       state_n = SET_M;
        else if (edit_inc) ih_n = wrap_inc(ih, 7'd23);
        else if (edit_dec) ih_n = wrap_dec(ih, 7'd23);
      end
      SET_M: begin
        if (btn_set)       state_n = SET_S;
        else if (edit_inc) im_n = wrap_inc(im, 7'd59);
        else if (edit_dec) im_n = wrap_dec(im, 7'd59);
      end
      SET_S: begin
        if (btn_set)       state_n = COMMIT;
        else if (edit_inc) is_n = wrap_inc(is, 7'd59);
        else if (edit_dec) is_n = wrap_dec(is, 7'd59);
      end
      COMMIT:  state_n = RUN;
      default: state_n = RUN;
    endcase

    // Idle timer counts down remaining ticks; any press restarts it.
    if (!in_set || any_btn) begin
      tmo_cnt_n = TMO_RELOAD;
    end else if (tick_1hz) begin
      if (tmo_cnt <= TW'(1)) begin
        state_n   = RUN;
        tmo_cnt_n = TMO_RELOAD;
      end else begin
        tmo_cnt_n = tmo_cnt - TW'(1);
      end
    end

    if (state_n != state || (in_set && (btn_inc || btn_dec))) begin
      blink_cnt_n = BLINK_RELOAD;
      pulse_n     = 1'b0;
    end else if (in_set) begin
      if (blink_cnt == '0) begin
        blink_cnt_n = BLINK_RELOAD;
        pulse_n     = ~pulse;
      end else begin
        blink_cnt_n = blink_cnt - BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      ih        <= 7'd0;
      im        <= 7'd0;
      is        <= 7'd0;
      blink_cnt <= BLINK_RELOAD;
      pulse     <= 1'b0;
      tmo_cnt   <= TMO_RELOAD;
      clockon   <= 1'b1;
      hset      <= 1'b0;
      mset      <= 1'b0;
      sset      <= 1'b0;
      load      <= 1'b0;
    end else begin
      state     <= state_n;
      ih        <= ih_n;
      im        <= im_n;
      is        <= is_n;
      blink_cnt <= blink_cnt_n;
      pulse     <= pulse_n;
      tmo_cnt   <= tmo_cnt_n;
      clockon   <= (state_n == RUN);
      hset      <= (state_n == SET_H);
      mset      <= (state_n == SET_M);
      sset      <= (state_n == SET_S);
      load      <= (state_n == COMMIT);
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed vector table, blink/timeout/reset sequences,
// and random stimulus against a mode/age/tick-count reference model.
module tb_time_set_controller;

  localparam int B = 4;
  localparam int T = 3;

  logic       clk, rst, tick_1hz, btn_set, btn_inc, btn_dec;
  logic [6:0] h, m, s, ih, im, is;
  logic       clockon, hset, mset, sset, pulse, load;

  time_set_controller #(.BLINK_CYCLES(B), .TIMEOUT_S(T)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .btn_set(btn_set), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .h(h), .m(m), .s(s), .ih(ih), .im(im), .is(is),
    .clockon(clockon), .hset(hset), .mset(mset), .sset(sset),
    .pulse(pulse), .load(load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: md 0=run 1=hours 2=minutes 3=seconds 4=commit
  int md, mh, mm, msec, age, tk;

  typedef struct {
    bit st, ic, dc;
    int hi, mi, si;
    bit co, hs, ms, ss, ld;
    int eh, em, es;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(bit st, bit ic, bit dc, int hi, int mi, int si,
                              bit co, bit hs, bit ms, bit ss, bit ld, int eh, int em, int es);
    vec_t v;
    v.st = st; v.ic = ic; v.dc = dc; v.hi = hi; v.mi = mi; v.si = si;
    v.co = co; v.hs = hs; v.ms = ms; v.ss = ss; v.ld = ld;
    v.eh = eh; v.em = em; v.es = es;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winc(input int v, input int mx);
    return (v >= mx) ? 0 : v + 1;
  endfunction

  function automatic int wdec(input int v, input int mx);
    return (v == 0 || v > mx) ? mx : v - 1;
  endfunction

  task automatic model_update(input bit st, input bit ic, input bit dc, input bit tc, input bit rs);
    int nm;
    if (rs) begin
      md = 0; mh = 0; mm = 0; msec = 0; age = 0; tk = 0;
      return;
    end
    nm = md;
    if (md == 0) begin
      if (st) begin
        mh = int'(h); mm = int'(m); msec = int'(s); nm = 1;
      end
    end else if (md == 4) begin
      nm = 0;
    end else begin
      if (st) nm = (md == 3) ? 4 : md + 1;
      else if (ic && !dc) begin
        if (md == 1) mh = winc(mh, 23);
        else if (md == 2) mm = winc(mm, 59);
        else msec = winc(msec, 59);
      end else if (dc && !ic) begin
        if (md == 1) mh = wdec(mh, 23);
        else if (md == 2) mm = wdec(mm, 59);
        else msec = wdec(msec, 59);
      end
      if (st || ic || dc) tk = 0;
      else if (tc) begin
        tk++;
        if (tk >= T) nm = 0;
      end
    end
    if (nm != md || (md >= 1 && md <= 3 && (ic || dc))) age = 0;
    else age++;
    if (nm != md) tk = 0;
    md = nm;
  endtask

  task automatic compare_model();
    chk("clockon", int'(clockon), int'(md == 0));
    chk("hset", int'(hset), int'(md == 1));
    chk("mset", int'(mset), int'(md == 2));
    chk("sset", int'(sset), int'(md == 3));
    chk("load", int'(load), int'(md == 4));
    chk("pulse", int'(pulse), (md >= 1 && md <= 3) ? (age / B) % 2 : 0);
    chk("ih", int'(ih), mh);
    chk("im", int'(im), mm);
    chk("is", int'(is), msec);
  endtask

  task automatic step(input bit st, input bit ic, input bit dc, input bit tc, input bit rs);
    btn_set = st; btn_inc = ic; btn_dec = dc; tick_1hz = tc; rst = rs;
    @(posedge clk);
    #1;
    model_update(st, ic, dc, tc, rs);
    btn_set = 0; btn_inc = 0; btn_dec = 0; tick_1hz = 0; rst = 0;
    compare_model();
  endtask

  initial begin
    btn_set = 0; btn_inc = 0; btn_dec = 0; tick_1hz = 0; rst = 1;
    h = 7'd0; m = 7'd0; s = 7'd0;
    md = 0; mh = 0; mm = 0; msec = 0; age = 0; tk = 0;

    repeat (3) step(0, 0, 0, 0, 1);
    repeat (100) step(0, 0, 0, 0, 0);
    chk("rst_clockon", int'(clockon), 1);
    chk("rst_selects", int'({hset, mset, sset}), 0);
    chk("rst_pulse_load", int'({pulse, load}), 0);
    chk("rst_fields", int'({ih, im, is}), 0);

    //           set inc dec  h   m   s   co hs ms ss ld  ih  im  is
    vt[0]  = mk(1, 0, 0, 13, 45,  7,  0, 1, 0, 0, 0, 13, 45,  7);
    vt[1]  = mk(0, 1, 0, 13, 45,  7,  0, 1, 0, 0, 0, 14, 45,  7);
    vt[2]  = mk(0, 1, 0, 13, 45,  7,  0, 1, 0, 0, 0, 15, 45,  7);
    vt[3]  = mk(1, 0, 0, 13, 45,  7,  0, 0, 1, 0, 0, 15, 45,  7);
    vt[4]  = mk(1, 1, 0, 13, 45,  7,  0, 0, 0, 1, 0, 15, 45,  7);
    vt[5]  = mk(1, 0, 0, 13, 45,  7,  0, 0, 0, 0, 1, 15, 45,  7);
    vt[6]  = mk(0, 0, 0, 13, 45,  7,  1, 0, 0, 0, 0, 15, 45,  7);
    vt[7]  = mk(1, 0, 0, 23,  0, 59,  0, 1, 0, 0, 0, 23,  0, 59);
    vt[8]  = mk(0, 1, 0, 23,  0, 59,  0, 1, 0, 0, 0,  0,  0, 59);
    vt[9]  = mk(0, 0, 1, 23,  0, 59,  0, 1, 0, 0, 0, 23,  0, 59);
    vt[10] = mk(1, 0, 0, 23,  0, 59,  0, 0, 1, 0, 0, 23,  0, 59);
    vt[11] = mk(0, 0, 1, 23,  0, 59,  0, 0, 1, 0, 0, 23, 59, 59);
    vt[12] = mk(0, 1, 1, 23,  0, 59,  0, 0, 1, 0, 0, 23, 59, 59);
    vt[13] = mk(1, 0, 0, 23,  0, 59,  0, 0, 0, 1, 0, 23, 59, 59);
    vt[14] = mk(0, 1, 0, 23,  0, 59,  0, 0, 0, 1, 0, 23, 59,  0);
    vt[15] = mk(1, 0, 0, 23,  0, 59,  0, 0, 0, 0, 1, 23, 59,  0);
    vt[16] = mk(0, 0, 0, 23,  0, 59,  1, 0, 0, 0, 0, 23, 59,  0);

    for (int i = 0; i < 17; i++) begin
      h = 7'(vt[i].hi); m = 7'(vt[i].mi); s = 7'(vt[i].si);
      step(vt[i].st, vt[i].ic, vt[i].dc, 0, 0);
      chk($sformatf("vec%0d_clockon", i), int'(clockon), int'(vt[i].co));
      chk($sformatf("vec%0d_sel", i), int'({hset, mset, sset}),
          int'({vt[i].hs, vt[i].ms, vt[i].ss}));
      chk($sformatf("vec%0d_load", i), int'(load), int'(vt[i].ld));
      chk($sformatf("vec%0d_ih", i), int'(ih), vt[i].eh);
      chk($sformatf("vec%0d_im", i), int'(im), vt[i].em);
      chk($sformatf("vec%0d_is", i), int'(is), vt[i].es);
    end

    // out-of-range capture: inc goes to 0, dec goes to max
    h = 7'd30; m = 7'd70; s = 7'd99;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("oor_h_inc", int'(ih), 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("oor_m_dec", int'(im), 59);
    step(0, 0, 0, 0, 1);

    // blink in SET_M, then an inc restarts the phase
    h = 7'd5; m = 7'd10; s = 7'd20;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("blink_entry", int'(pulse), 0);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("blink_k%0d", k), int'(pulse), (k / 4) % 2);
    end
    step(0, 1, 0, 0, 0);
    chk("blink_after_inc", int'(pulse), 0);
    chk("blink_inc_im", int'(im), 11);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("blink_restart_k%0d", k), int'(pulse), (k / 4) % 2);
    end
    step(0, 0, 0, 0, 1);

    // timeout after T idle ticks, values retained, no load
    h = 7'd8; m = 7'd9; s = 7'd10;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("tmo_before", int'(hset), 1);
    step(0, 0, 0, 1, 0);
    chk("tmo_abort_clockon", int'(clockon), 1);
    chk("tmo_abort_load", int'(load), 0);
    chk("tmo_keep_ih", int'(ih), 8);
    repeat (3) begin
      step(0, 0, 0, 0, 0);
      chk("tmo_no_load", int'(load), 0);
    end

    // a press before the last tick restarts the idle count
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("tmo_held_hset", int'(hset), 1);
    chk("tmo_held_ih", int'(ih), 9);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("pre_rst_sset", int'(sset), 1);
    step(1, 0, 0, 0, 1);
    chk("rst_mid_clockon", int'(clockon), 1);
    chk("rst_mid_load", int'(load), 0);
    chk("rst_mid_fields", int'({ih, im, is}), 0);
    step(0, 0, 0, 0, 0);
    chk("rst_mid_load_next", int'(load), 0);

    // random stimulus against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        h = 7'($urandom_range(0, 127));
        m = 7'($urandom_range(0, 127));
        s = 7'($urandom_range(0, 127));
      end
      step($urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 499) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
